// File: rtl/seg7_pkg.sv
// Shared seven-segment types and BCD decode for the scroller.
// Exports SEG_BLANK, bcd_t, seg_t and bcd_to_seg (active-low a..g).
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  function automatic seg_t bcd_to_seg(input bcd_t v);
    seg_t s;
    s = SEG_BLANK;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder.
// Ports: bcd (in, bcd_t), seg (out, seg_t; 10..15 blank).
module seg7_decode
  import seg7_pkg::*;
(
  input  bcd_t bcd,
  output seg_t seg
);

  assign seg = bcd_to_seg(bcd);

endmodule

// File: rtl/seg_scroll_display.sv
// Multiplexed seven-segment scroller over a writable BCD sequence.
// Ports: clk, rst (async high), en, dir, wr_en/wr_addr/wr_data in;
// seg, an (active low), pos out; dp out with SEG_SCROLL_DP_EN.
module seg_scroll_display
  import seg7_pkg::*;
#(
  parameter int SEQ_LEN     = 8,
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int SCROLL_DIV  = 25000000,
  parameter logic [4*SEQ_LEN-1:0] SEQ_INIT = 32'h3010_8991
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       dir,
  input  logic                       wr_en,
  input  logic [$clog2(SEQ_LEN)-1:0] wr_addr,
  input  logic [3:0]                 wr_data,
  output logic [6:0]                 seg,
  output logic [NUM_DIGITS-1:0]      an,
`ifdef SEG_SCROLL_DP_EN
  output logic                       dp,
`endif
  output logic [$clog2(SEQ_LEN)-1:0] pos
);

  localparam int AW  = $clog2(SEQ_LEN);
  localparam int AW1 = AW + 1;
  localparam int RW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int CW  = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int SW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [RW-1:0]  REF_LAST  = RW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]  SCR_LAST  = CW'(SCROLL_DIV - 1);
  localparam logic [SW-1:0]  SCAN_LAST = SW'(NUM_DIGITS - 1);
  localparam logic [AW-1:0]  POS_LAST  = AW'(SEQ_LEN - 1);
  localparam logic [AW1-1:0] LEN_W     = AW1'(SEQ_LEN);

  bcd_t seq_q [SEQ_LEN];
  bcd_t seq_d [SEQ_LEN];

  logic [RW-1:0]         ref_q, ref_d;
  logic [CW-1:0]         scr_q, scr_d;
  logic [SW-1:0]         scan_q, scan_d;
  logic [AW-1:0]         pos_q, pos_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic [AW1-1:0] sum;
  logic [AW-1:0]  disp_idx;
  bcd_t           digit;
  seg_t           dec_seg;

  seg7_decode u_dec (
    .bcd (digit),
    .seg (dec_seg)
  );

  always_comb begin
    ref_d  = ref_q + 1'b1;
    scan_d = scan_q;
    if (ref_q == REF_LAST) begin
      ref_d  = '0;
      scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
    end

    scr_d = scr_q;
    pos_d = pos_q;
    if (en) begin
      scr_d = scr_q + 1'b1;
      if (scr_q == SCR_LAST) begin
        scr_d = '0;
        if (dir) pos_d = (pos_q == '0) ? POS_LAST : pos_q - 1'b1;
        else     pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
      end
    end

    seq_d = seq_q;
    if (wr_en && ({1'b0, wr_addr} < LEN_W)) begin
      seq_d[wr_addr] = wr_data;
    end

    // pos < SEQ_LEN and scan < SEQ_LEN, so one subtract wraps
    sum = {1'b0, pos_q} + AW1'(scan_q);
    if (sum >= LEN_W) sum = sum - LEN_W;
    disp_idx = sum[AW-1:0];
    digit    = seq_q[disp_idx];

    seg_d = dec_seg;
    an_d  = ~(NUM_DIGITS'(1) << scan_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SEQ_LEN; i++) begin
        seq_q[i] <= SEQ_INIT[4*i +: 4];
      end
      ref_q  <= '0;
      scr_q  <= '0;
      scan_q <= '0;
      pos_q  <= '0;
      seg_q  <= SEG_BLANK;
      an_q   <= '1;
    end else begin
      seq_q  <= seq_d;
      ref_q  <= ref_d;
      scr_q  <= scr_d;
      scan_q <= scan_d;
      pos_q  <= pos_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign pos = pos_q;

`ifdef SEG_SCROLL_DP_EN
  logic dp_q, dp_d;

  // Marks the first digit of the stored sequence.
  always_comb dp_d = (disp_idx != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dp_q <= 1'b1;
    else     dp_q <= dp_d;
  end

  assign dp = dp_q;
`endif

endmodule

// File: tb/tb_seg_scroll_display.sv
// Randomised self-checking bench for seg_scroll_display.
// Reference model derives scan/scroll state from elapsed cycle counts.
module tb_seg_scroll_display;

  localparam int L  = 8;
  localparam int ND = 4;
  localparam int RD = 2;
  localparam int SD = 8;
  localparam logic [31:0] INIT = 32'h3010_8991;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       dir = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic [6:0] seg;
  logic [3:0] an;
  logic [2:0] pos;
`ifdef SEG_SCROLL_DP_EN
  logic       dp;
`endif

  seg_scroll_display #(
    .SEQ_LEN     (L),
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .SCROLL_DIV  (SD),
    .SEQ_INIT    (INIT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .dir     (dir),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .seg     (seg),
    .an      (an),
`ifdef SEG_SCROLL_DP_EN
    .dp      (dp),
`endif
    .pos     (pos)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int m_seq [L];
  int m_pos, m_cyc, m_ecnt;
  logic [6:0] exp_seg;
  logic [3:0] exp_an;
  logic       exp_dp;

  function automatic logic [6:0] ref_dec(input int v);
    logic [6:0] pat [10];
    pat = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (v >= 0 && v < 10) return pat[v];
    return 7'h7F;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < L; i++) m_seq[i] = int'((INIT >> (4*i)) & 32'hF);
    m_pos  = 0;
    m_cyc  = 0;
    m_ecnt = 0;
  endtask

  // One clock: expected outputs come from pre-edge model state,
  // then the model absorbs the inputs sampled at this edge.
  task automatic tick();
    int k, idx;
    k       = (m_cyc / RD) % ND;
    idx     = (m_pos + k) % L;
    exp_seg = ref_dec(m_seq[idx]);
    exp_an  = ~(4'b0001 << k);
    exp_dp  = (idx != 0);
    m_cyc++;
    if (en) begin
      m_ecnt++;
      if (m_ecnt % SD == 0)
        m_pos = dir ? (m_pos + L - 1) % L : (m_pos + 1) % L;
    end
    if (wr_en && int'(wr_addr) < L) m_seq[wr_addr] = int'(wr_data);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    en = 0; dir = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
    rst = 1;
    #2;
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    total++;
    if (seg !== 7'h7F) begin
      bad++; $display("FAIL reset_seg got %h want 7f", seg);
    end
    total++;
    if (an !== 4'hF) begin
      bad++; $display("FAIL reset_an got %b want 1111", an);
    end
    total++;
    if (pos !== 3'd0) begin
      bad++; $display("FAIL reset_pos got %0d want 0", pos);
    end
`ifdef SEG_SCROLL_DP_EN
    total++;
    if (dp !== 1'b1) begin
      bad++; $display("FAIL reset_dp got %b want 1", dp);
    end
`endif
    #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_scan();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      tick();
      total++;
      if (an !== exp_an) begin
        bad++; $display("FAIL scan_an got %b want %b", an, exp_an);
      end
      total++;
      if (seg !== exp_seg) begin
        bad++; $display("FAIL scan_seg got %h want %h", seg, exp_seg);
      end
      total++;
      if (pos !== 3'd0) begin
        bad++; $display("FAIL scan_pos got %0d want 0", pos);
      end
    end
  endtask

  task automatic test_forward();
    logic [6:0] win [4];
    win = '{7'h40, 7'h30, 7'h79, 7'h10};
    do_reset();
    en = 1;
    for (int i = 0; i < 64; i++) begin
      tick();
      total++;
      if (pos !== 3'(m_pos)) begin
        bad++; $display("FAIL fwd_pos got %0d want %0d", pos, m_pos);
      end
      total++;
      if (seg !== exp_seg || an !== exp_an) begin
        bad++;
        $display("FAIL fwd_disp got %h/%b want %h/%b",
                 seg, an, exp_seg, exp_an);
      end
      if (i >= 48 && i < 56 && i % 2 == 0) begin
        total++;
        if (seg !== win[(i-48)/2]) begin
          bad++;
          $display("FAIL fwd_window got %h want %h",
                   seg, win[(i-48)/2]);
        end
      end
    end
    total++;
    if (pos !== 3'd0) begin
      bad++; $display("FAIL fwd_wrap got %0d want 0", pos);
    end
  endtask

  task automatic test_reverse_pause();
    do_reset();
    en  = 1;
    dir = 1;
    repeat (8) tick();
    total++;
    if (pos !== 3'd7) begin
      bad++; $display("FAIL rev_wrap got %0d want 7", pos);
    end
    repeat (3) tick();
    en = 0;
    repeat (20) tick();
    total++;
    if (pos !== 3'd7) begin
      bad++; $display("FAIL pause_hold got %0d want 7", pos);
    end
    en = 1;
    repeat (4) tick();
    total++;
    if (pos !== 3'd7) begin
      bad++; $display("FAIL resume_early got %0d want 7", pos);
    end
    tick();
    total++;
    if (pos !== 3'd6) begin
      bad++; $display("FAIL resume_step got %0d want 6", pos);
    end
  endtask

  task automatic test_write();
    do_reset();
    wr_en   = 1;
    wr_addr = 3'd1;
    wr_data = 4'hC;
    tick();
    wr_en = 0;
    tick();
    tick();
    total++;
    if (seg !== 7'h7F || an !== 4'b1101) begin
      bad++; $display("FAIL write_blank got %h/%b want 7f/1101", seg, an);
    end
    wr_data = 4'h9;
    repeat (8) tick();
    total++;
    if (seg !== 7'h7F || an !== 4'b1101) begin
      bad++; $display("FAIL write_idle got %h/%b want 7f/1101", seg, an);
    end
    total++;
    if (seg !== exp_seg) begin
      bad++; $display("FAIL write_model got %h want %h", seg, exp_seg);
    end
  endtask

  task automatic test_collision();
    do_reset();
    en = 1;
    repeat (7) tick();
    wr_en   = 1;
    wr_addr = 3'd1;
    wr_data = 4'h5;
    tick();
    wr_en = 0;
    total++;
    if (pos !== 3'd1) begin
      bad++; $display("FAIL coll_pos got %0d want 1", pos);
    end
    tick();
    total++;
    if (seg !== 7'h12 || an !== 4'b1110) begin
      bad++; $display("FAIL coll_seg got %h/%b want 12/1110", seg, an);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 1;
    repeat (37) tick();
    rst = 1;
    #1;
    total++;
    if (seg !== 7'h7F || an !== 4'hF) begin
      bad++; $display("FAIL mid_rst_out got %h/%b want 7f/1111", seg, an);
    end
    total++;
    if (pos !== 3'd0) begin
      bad++; $display("FAIL mid_rst_pos got %0d want 0", pos);
    end
    #2;
    rst = 0;
    en  = 0;
    model_reset();
    tick();
    total++;
    if (seg !== 7'h79 || an !== 4'b1110) begin
      bad++; $display("FAIL mid_rst_first got %h/%b want 79/1110", seg, an);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      en      = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      wr_en   = ($urandom_range(0, 4) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 4'($urandom_range(0, 15));
      tick();
      total++;
      if (seg !== exp_seg) begin
        bad++; $display("FAIL rnd_seg got %h want %h", seg, exp_seg);
      end
      total++;
      if (an !== exp_an) begin
        bad++; $display("FAIL rnd_an got %b want %b", an, exp_an);
      end
      total++;
      if (pos !== 3'(m_pos)) begin
        bad++; $display("FAIL rnd_pos got %0d want %0d", pos, m_pos);
      end
`ifdef SEG_SCROLL_DP_EN
      total++;
      if (dp !== exp_dp) begin
        bad++; $display("FAIL rnd_dp got %b want %b", dp, exp_dp);
      end
`endif
    end
    wr_en = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scan();
    test_forward();
    test_reverse_pause();
    test_write();
    test_collision();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
